// File: rtl/seq_comb_pipe.sv
// seq_comb_pipe: elastic pipeline of CH independent WIDTH-bit channels,
// DEPTH register stages deep, valid/ready handshake at both ends.
// The output stage data is re-derived through several combinational styles
// (continuous assign, always @(*), always_comb, gate primitives) and a
// registered checker flags any disagreement between those views.
module seq_comb_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3,
  parameter int CH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*WIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*WIDTH-1:0] out_data,
  output logic [CH*WIDTH-1:0] out_inc,
  output logic                mismatch,
  output logic [15:0]         beat_count
);

  localparam int DW = CH * WIDTH;

  // Pipeline stage state
  logic [DEPTH-1:0]         v_q;
  logic [DEPTH-1:0]         v_d;
  logic [DEPTH-1:0][DW-1:0] d_q;
  logic [DEPTH-1:0][DW-1:0] d_d;

  // Stage k may load this cycle. Unrolled form of r[k] = !v[k] || r[k+1]:
  // a stage can advance if the sink is ready or any stage from k down to the
  // output holds a bubble. Kept non-recursive so no combinational self-loop.
  wire  [DEPTH-1:0]         ready_s;

  // Output-stage views
  logic [DW-1:0] dout_s;
  logic [DW-1:0] view_a_s;
  logic [DW-1:0] view_b_s;
  logic [DW-1:0] view_c_s;
  wire  [DW-1:0] view_d_s;
  wire  [DW-1:0] view_e_s;
  wire  [DW-1:0] view_f_s;
  logic [DW-1:0] view_g_s;

  // Checker and counter state
  logic          err_s;
  logic          mismatch_q;
  logic          mismatch_d;
  logic [15:0]   beat_count_q;
  logic [15:0]   beat_count_d;

  genvar gk;
  genvar gb;
  genvar gc;

  generate
    for (gk = 0; gk < DEPTH; gk++) begin : g_ready
      assign ready_s[gk] = out_ready | ~(&v_q[DEPTH-1:gk]);
    end
  endgenerate

  // Stage advance: a ready stage loads its upstream neighbour, otherwise holds.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (ready_s[0]) begin
      v_d[0] = in_valid;
      d_d[0] = in_data;
    end else begin
      v_d[0] = v_q[0];
      d_d[0] = d_q[0];
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (ready_s[k]) begin
        v_d[k] = v_q[k-1];
        d_d[k] = d_q[k-1];
      end else begin
        v_d[k] = v_q[k];
        d_d[k] = d_q[k];
      end
    end
  end

  // Final stage feeds every view.
  assign dout_s = d_q[DEPTH-1];

  // View A: continuous assignment copy.
  assign view_a_s = dout_s;

  // View B: classic always @(*) copy.
  always @(*) begin
    view_b_s = dout_s;
  end

  // View C: always_comb copy.
  always_comb begin
    view_c_s = dout_s;
  end

  // Views D and E: per-bit buf and self-and primitives (both propagate X).
  generate
    for (gb = 0; gb < DW; gb++) begin : g_bit
      buf u_buf (view_d_s[gb], dout_s[gb]);
      and u_and (view_e_s[gb], dout_s[gb], dout_s[gb]);
    end
  endgenerate

  // View F: per-channel increment via continuous assignment, wraps at 2^WIDTH.
  generate
    for (gc = 0; gc < CH; gc++) begin : g_inc
      assign view_f_s[gc*WIDTH +: WIDTH] = dout_s[gc*WIDTH +: WIDTH] + WIDTH'(1'b1);
    end
  endgenerate

  // View G: per-channel increment via always_comb.
  always_comb begin
    view_g_s = '0;
    for (int c = 0; c < CH; c++) begin
      view_g_s[c*WIDTH +: WIDTH] = dout_s[c*WIDTH +: WIDTH] + WIDTH'(1'b1);
    end
  end

  // Disagreement between any views; !== so views also agree while still X.
  always_comb begin
    err_s = (view_b_s !== view_a_s) |
            (view_c_s !== view_a_s) |
            (view_d_s !== view_a_s) |
            (view_e_s !== view_a_s) |
            (view_g_s !== view_f_s);
    for (int c = 0; c < CH; c++) begin
      err_s = err_s |
              (view_f_s[c*WIDTH +: WIDTH] !== (view_a_s[c*WIDTH +: WIDTH] + WIDTH'(1'b1)));
    end
  end

  // Sticky mismatch accumulates only while an output beat is present.
  always_comb begin
    if (v_q[DEPTH-1]) begin
      mismatch_d = mismatch_q | err_s;
    end else begin
      mismatch_d = mismatch_q;
    end
  end

  // Output handshake counter, saturating at all-ones.
  always_comb begin
    if (v_q[DEPTH-1] && out_ready && (beat_count_q != 16'hFFFF)) begin
      beat_count_d = beat_count_q + 16'h0001;
    end else begin
      beat_count_d = beat_count_q;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q          <= '0;
      d_q          <= '0;
      mismatch_q   <= 1'b0;
      beat_count_q <= 16'h0000;
    end else begin
      v_q          <= v_d;
      d_q          <= d_d;
      mismatch_q   <= mismatch_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign in_ready   = ready_s[0];
  assign out_valid  = v_q[DEPTH-1];
  assign out_data   = view_a_s;
  assign out_inc    = view_f_s;
  assign mismatch   = mismatch_q;
  assign beat_count = beat_count_q;

endmodule

// File: tb/tb_seq_comb_pipe.sv
// Directed bench for seq_comb_pipe: default instance (WIDTH=4, DEPTH=3, CH=2)
// for the directed scenarios, and a WIDTH=7, DEPTH=5, CH=3 instance for the
// random handshake scenario checked against a scoreboard.
module tb_seq_comb_pipe;

  localparam int D1  = 3;
  localparam int D2  = 5;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [7:0]  out_inc;
  logic        mismatch;
  logic [15:0] beat_count;

  logic        in_valid2;
  logic        in_ready2;
  logic [20:0] in_data2;
  logic        out_valid2;
  logic        out_ready2;
  logic [20:0] out_data2;
  logic [20:0] out_inc2;
  logic        mismatch2;
  logic [15:0] beat_count2;

  int n_cmp;
  int n_err;

  seq_comb_pipe #(.WIDTH(4), .DEPTH(D1), .CH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_inc    (out_inc),
    .mismatch   (mismatch),
    .beat_count (beat_count)
  );

  seq_comb_pipe #(.WIDTH(7), .DEPTH(D2), .CH(3)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .in_data    (in_data2),
    .out_valid  (out_valid2),
    .out_ready  (out_ready2),
    .out_data   (out_data2),
    .out_inc    (out_inc2),
    .mismatch   (mismatch2),
    .beat_count (beat_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    in_valid2 = 1'b0; out_ready2 = 1'b0; in_data2 = 21'h0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_cmp++; if (out_inc !== 8'h11) begin n_err++; $display("FAIL reset_out_inc: got %h want 11", out_inc); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL reset_mismatch: got %b want 0", mismatch); end
    n_cmp++; if (beat_count !== 16'h0000) begin n_err++; $display("FAIL reset_beat_count: got %h want 0000", beat_count); end
    n_cmp++; if (out_inc2 !== {7'd1, 7'd1, 7'd1}) begin n_err++; $display("FAIL reset_out_inc2: got %h want %h", out_inc2, {7'd1, 7'd1, 7'd1}); end
    n_cmp++; if (out_valid2 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid2: got %b want 0", out_valid2); end
  endtask

  task automatic test_stream();
    logic [3:0] ev;
    out_ready = 1'b1;
    for (int t = 0; t < 16 + D1; t++) begin
      in_valid = (t < 16);
      in_data  = {t[3:0], t[3:0]};
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready t=%0d: got %b want 1", t, in_ready); end
      if (t >= D1) begin
        ev = 4'(t - D1);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_out_valid t=%0d: got %b want 1", t, out_valid); end
        n_cmp++; if (out_data !== {ev, ev}) begin n_err++; $display("FAIL stream_out_data t=%0d: got %h want %h", t, out_data, {ev, ev}); end
        n_cmp++; if (out_inc !== {ev + 4'h1, ev + 4'h1}) begin n_err++; $display("FAIL stream_out_inc t=%0d: got %h want %h", t, out_inc, {ev + 4'h1, ev + 4'h1}); end
        if (t == 15 + D1) begin
          n_cmp++; if (out_inc !== 8'h00) begin n_err++; $display("FAIL stream_wrap_inc: got %h want 00", out_inc); end
        end
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_latency t=%0d: got %b want 0", t, out_valid); end
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_cmp++; if (beat_count !== 16'd16) begin n_err++; $display("FAIL stream_beat_count: got %0d want 16", beat_count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drained: got %b want 0", out_valid); end
    n_cmp++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL stream_mismatch: got %b want 0", mismatch); end
  endtask

  task automatic test_stall();
    logic [7:0] sb[$];
    logic [7:0] nxt;
    logic       acc;
    logic       pop;
    int         acc_n;
    int         pop_n;
    nxt = 8'h31; acc_n = 0; pop_n = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int t = 0; t < 6; t++) begin
      in_data = nxt;
      #1;
      if (out_valid) begin
        n_cmp++; if (out_data !== 8'h31) begin n_err++; $display("FAIL stall_stable t=%0d: got %h want 31", t, out_data); end
      end
      if (in_ready) begin
        sb.push_back(nxt);
        nxt = nxt + 8'h11;
        acc_n++;
      end
      tick();
    end
    #1;
    n_cmp++; if (acc_n !== D1) begin n_err++; $display("FAIL stall_accepted: got %0d want %0d", acc_n, D1); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready_low: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid: got %b want 1", out_valid); end
    out_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      in_valid = (t < 3);
      in_data  = nxt;
      #1;
      if (t == 0) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
      end
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL stall_extra_beat: got %h want none", out_data);
        end else begin
          if (out_data !== sb[0]) begin n_err++; $display("FAIL stall_order: got %h want %h", out_data, sb[0]); end
          void'(sb.pop_front());
        end
        pop_n++;
      end
      if (acc) begin
        sb.push_back(nxt);
        nxt = nxt + 8'h11;
        acc_n++;
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL stall_lost: got %0d pending want 0", sb.size()); end
    n_cmp++; if (pop_n != acc_n) begin n_err++; $display("FAIL stall_counts: got %0d out want %0d", pop_n, acc_n); end
    n_cmp++; if (beat_count !== 16'(16 + acc_n)) begin n_err++; $display("FAIL stall_beat_count: got %0d want %0d", beat_count, 16 + acc_n); end
    n_cmp++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL stall_mismatch: got %b want 0", mismatch); end
  endtask

  task automatic test_random();
    logic [20:0] sb[$];
    logic [20:0] e;
    logic [20:0] ei;
    logic        acc;
    logic        pop;
    int          pops;
    pops = 0;
    for (int t = 0; t < 10000; t++) begin
      if (t < 9990) begin
        in_valid2  = 1'($urandom_range(0, 1));
        out_ready2 = 1'($urandom_range(0, 1));
      end else begin
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
      end
      in_data2 = 21'($urandom);
      #1;
      acc = in_valid2 && in_ready2;
      pop = out_valid2 && out_ready2;
      if (pop) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL random_extra_beat t=%0d: got %h want none", t, out_data2);
        end else begin
          e  = sb.pop_front();
          ei = {e[20:14] + 7'd1, e[13:7] + 7'd1, e[6:0] + 7'd1};
          if (out_data2 !== e || out_inc2 !== ei) begin
            n_err++; $display("FAIL random_beat t=%0d: got %h/%h want %h/%h", t, out_data2, out_inc2, e, ei);
          end
        end
        pops++;
      end
      if (acc) sb.push_back(in_data2);
      tick();
    end
    #1;
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL random_lost: got %0d pending want 0", sb.size()); end
    n_cmp++; if (mismatch2 !== 1'b0) begin n_err++; $display("FAIL random_mismatch: got %b want 0", mismatch2); end
    n_cmp++; if (beat_count2 !== 16'(pops)) begin n_err++; $display("FAIL random_beat_count: got %0d want %0d", beat_count2, pops); end
    n_cmp++; if (pops < 1000) begin n_err++; $display("FAIL random_throughput: got %0d beats want >=1000", pops); end
  endtask

  task automatic test_midreset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int t = 0; t < D1 + 1; t++) begin
      in_data = 8'(8'hC0 + t);
      tick();
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_full: got %b want 1", out_valid); end
    rst       = 1'b1;
    in_data   = 8'hEE;
    out_ready = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (beat_count !== 16'h0000) begin n_err++; $display("FAIL midrst_beat_count: got %0d want 0", beat_count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    for (int t = 0; t < 8; t++) begin
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_ghost t=%0d: got %h want no beat", t, out_data); end
      tick();
    end
    n_cmp++; if (beat_count !== 16'h0000) begin n_err++; $display("FAIL midrst_count_after: got %0d want 0", beat_count); end
  endtask

  task automatic test_force_c();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    tick();
    in_valid = 1'b0;
    for (int w = 0; w < 10 && out_valid !== 1'b1; w++) tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL force_wait_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'h5A) begin n_err++; $display("FAIL force_data: got %h want 5a", out_data); end
    n_cmp++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL force_pre_mismatch: got %b want 0", mismatch); end
    force dut.view_c_s = 8'hA5;
    tick();
    release dut.view_c_s;
    #1;
    n_cmp++; if (mismatch !== 1'b1) begin n_err++; $display("FAIL force_mismatch_set: got %b want 1", mismatch); end
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    n_cmp++; if (mismatch !== 1'b1) begin n_err++; $display("FAIL force_mismatch_sticky: got %b want 1", mismatch); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL force_mismatch_clear: got %b want 0", mismatch); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_stream();
    test_stall();
    test_random();
    test_midreset();
    test_force_c();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
